// File: rtl/palette_ram_wr_pkg.sv
// Shared NES constants for the palette RAM write path: base page, init colour, FSM states, increments.
// No logic; constants and a small helper only.
// No flow control in this file.
package palette_ram_wr_pkg;

  // VRAM page (vaddr[13:8]) that maps onto the palette
  localparam logic [5:0]  PAL_BASE    = 6'h3F;
  // Colour written into every entry by the post-reset fill
  localparam logic [5:0]  INIT_COLOUR = 6'h0F;
  // Number of palette entries; the fill counter is sized to cover exactly these
  localparam int          PAL_ENTRIES = 32;
  localparam logic [4:0]  LAST_ENTRY  = 5'd31;

  // VRAM address increments after a data-port access
  localparam logic [13:0] INC_ONE     = 14'd1;
  localparam logic [13:0] INC_ROW     = 14'd32;

  // INIT fills the palette, IDLE accepts CPU accesses
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } pal_state_t;

  // Select the post-access VRAM address step
  function automatic logic [13:0] vaddr_step(input logic inc32);
    return inc32 ? INC_ROW : INC_ONE;
  endfunction

endpackage

// File: rtl/palette_ram_wr_mirror.sv
// Palette index mirror: 0x10/0x14/0x18/0x1C alias onto 0x00/0x04/0x08/0x0C.
// Purely combinational, zero latency.
// No flow control.
module palette_mirror (
  input  logic [4:0] idx,
  output logic [4:0] mirrored
);

  // Sprite backdrop slots share storage with the matching background slots
  always_comb begin
    mirrored = idx;
    if (idx[4] && (idx[1:0] == 2'b00)) begin
      mirrored = {1'b0, idx[3:0]};
    end
  end

endmodule

// File: rtl/palette_ram_wr.sv
// 32x6 palette RAM with NES-style address/data CPU ports; optional readback under PALETTE_READBACK_EN.
// Writes land one cycle after the strobe; renderer read is combinational; readback registers 1 cycle later.
// ready is low during the 32-cycle post-reset fill; CPU strobes are dropped while it is low.
module palette_ram_wr
  import palette_ram_wr_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_we,
  input  logic        cpu_sel,
  input  logic [7:0]  cpu_din,
  input  logic        inc32,
`ifdef PALETTE_READBACK_EN
  input  logic        cpu_re,
  output logic [7:0]  cpu_dout,
`endif
  output logic        ready,
  output logic [13:0] vaddr,
  input  logic [4:0]  rd_addr,
  output logic [5:0]  rd_dout
);

  pal_state_t  state;
  logic [4:0]  init_cnt;
  logic        w;

  logic [5:0]  pal [PAL_ENTRIES];

  logic [4:0]  wr_idx;
  logic [4:0]  rnd_idx;

  logic        acc_we;
  logic        addr_wr;
  logic        data_wr;
  logic        data_acc;
  logic        pal_hit;

  logic        pal_we;
  logic [4:0]  pal_widx;
  logic [5:0]  pal_wdat;

  // Write path and renderer path each get their own mirror
  palette_mirror u_mirror_wr (
    .idx      (vaddr[4:0]),
    .mirrored (wr_idx)
  );

  palette_mirror u_mirror_rnd (
    .idx      (rd_addr),
    .mirrored (rnd_idx)
  );

`ifdef PALETTE_READBACK_EN
  logic        acc_re;
  logic [4:0]  rb_idx;

  palette_mirror u_mirror_rb (
    .idx      (vaddr[4:0]),
    .mirrored (rb_idx)
  );

  // A read sharing a cycle with a write is dropped; the write wins
  assign acc_re   = ready & cpu_re & cpu_sel & ~cpu_we;
`endif

  assign acc_we  = ready & cpu_we;
  assign addr_wr = acc_we & ~cpu_sel;
  assign data_wr = acc_we & cpu_sel;
  assign pal_hit = (vaddr[13:8] == PAL_BASE);

`ifdef PALETTE_READBACK_EN
  assign data_acc = data_wr | acc_re;
`else
  assign data_acc = data_wr;
`endif

  // Palette write port arbitration: the fill owns the RAM in INIT, the CPU data port in IDLE
  always_comb begin
    pal_we   = 1'b0;
    pal_widx = init_cnt;
    pal_wdat = INIT_COLOUR;
    if (state == ST_INIT) begin
      pal_we   = 1'b1;
      pal_widx = init_cnt;
      pal_wdat = INIT_COLOUR;
    end else if (data_wr && pal_hit) begin
      pal_we   = 1'b1;
      pal_widx = wr_idx;
      pal_wdat = cpu_din[5:0];
    end
  end

  // Palette storage; deliberately not reset, the fill rewrites every entry
  always_ff @(posedge clk) begin
    if (pal_we) begin
      pal[pal_widx] <= pal_wdat;
    end
  end

  // Renderer lookup, same-cycle
  assign rd_dout = pal[rnd_idx];

  // Control FSM: init fill, address-port toggle, VRAM address stepping and readback register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_INIT;
      init_cnt <= 5'd0;
      vaddr    <= 14'd0;
      w        <= 1'b0;
      ready    <= 1'b0;
`ifdef PALETTE_READBACK_EN
      cpu_dout <= 8'd0;
`endif
    end else begin
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + 5'd1;
          if (init_cnt == LAST_ENTRY) begin
            state <= ST_IDLE;
            ready <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (addr_wr) begin
            // High byte first; only 6 bits of it exist in the 14-bit address
            if (!w) begin
              vaddr[13:8] <= cpu_din[5:0];
            end else begin
              vaddr[7:0]  <= cpu_din;
            end
            w <= ~w;
          end else if (data_acc) begin
            // 14-bit add wraps naturally at the top of VRAM
            vaddr <= vaddr + vaddr_step(inc32);
          end
`ifdef PALETTE_READBACK_EN
          if (acc_re) begin
            cpu_dout <= {2'b00, pal[rb_idx]};
          end
`endif
        end
        default: begin
          state <= ST_INIT;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_palette_ram_wr.sv
// Directed self-checking bench for palette_ram_wr (readback section active with PALETTE_READBACK_EN).
// Stimulus is applied on the falling edge; outputs are sampled away from the rising edge.
// Every wait on the DUT is cycle-bounded.
module tb_palette_ram_wr;

  logic        clk;
  logic        rst;
  logic        cpu_we;
  logic        cpu_sel;
  logic [7:0]  cpu_din;
  logic        inc32;
  logic        ready;
  logic [13:0] vaddr;
  logic [4:0]  rd_addr;
  logic [5:0]  rd_dout;
`ifdef PALETTE_READBACK_EN
  logic        cpu_re;
  logic [7:0]  cpu_dout;
`endif

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_view [32];

  palette_ram_wr dut (
    .clk     (clk),
    .rst     (rst),
    .cpu_we  (cpu_we),
    .cpu_sel (cpu_sel),
    .cpu_din (cpu_din),
    .inc32   (inc32),
`ifdef PALETTE_READBACK_EN
    .cpu_re  (cpu_re),
    .cpu_dout(cpu_dout),
`endif
    .ready   (ready),
    .vaddr   (vaddr),
    .rd_addr (rd_addr),
    .rd_dout (rd_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cpu_wr(input logic sel, input logic [7:0] din, input logic i32);
    @(negedge clk);
    cpu_we  = 1'b1;
    cpu_sel = sel;
    cpu_din = din;
    inc32   = i32;
    @(negedge clk);
    cpu_we  = 1'b0;
  endtask

  task automatic set_addr(input logic [15:0] a);
    cpu_wr(1'b0, a[15:8], 1'b0);
    cpu_wr(1'b0, a[7:0], 1'b0);
  endtask

  // Count falling edges with ready low, starting at the edge where rst drops
  task automatic fill_count(output int n);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (ready) break;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic init_view();
    for (int i = 0; i < 32; i++) exp_view[i] = 6'h0F;
  endtask

  task automatic check_view(input string tag);
    for (int i = 0; i < 32; i++) begin
      rd_addr = i[4:0];
      #1;
      chk($sformatf("%s_rd%0d", tag, i), {26'd0, rd_dout}, {26'd0, exp_view[i]});
    end
  endtask

`ifdef PALETTE_READBACK_EN
  task automatic cpu_rd();
    @(negedge clk);
    cpu_re  = 1'b1;
    cpu_sel = 1'b1;
    @(negedge clk);
    cpu_re  = 1'b0;
  endtask
`endif

  initial begin
    int n;
    rst = 1'b1; cpu_we = 1'b0; cpu_sel = 1'b0; cpu_din = 8'h00; inc32 = 1'b0; rd_addr = 5'd0;
`ifdef PALETTE_READBACK_EN
    cpu_re = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_vaddr", {18'd0, vaddr}, 32'h0);
`ifdef PALETTE_READBACK_EN
    chk("rst_cpu_dout", {24'd0, cpu_dout}, 32'h0);
`endif

    // Power-up fill
    rst = 1'b0;
    fill_count(n);
    chk("fill_len", n, 32);
    chk("ready_idle", {31'd0, ready}, 32'd1);
    init_view();
    check_view("init");

    // Two consecutive palette writes with +1
    set_addr(16'h3F01);
    chk("addr_3f01", {18'd0, vaddr}, 32'h3F01);
    cpu_wr(1'b1, 8'h16, 1'b0);
    rd_addr = 5'd1; #1;
    chk("visible_next_cycle", {26'd0, rd_dout}, 32'h16);
    cpu_wr(1'b1, 8'h27, 1'b0);
    exp_view[1] = 6'h16;
    exp_view[2] = 6'h27;
    chk("vaddr_3f03", {18'd0, vaddr}, 32'h3F03);
    check_view("seq");

    // Mirrored write at 0x10 lands in entry 0; upper bits of data dropped
    set_addr(16'h3F10);
    cpu_wr(1'b1, 8'hFF, 1'b0);
    exp_view[0]  = 6'h3F;
    exp_view[16] = 6'h3F;
    chk("vaddr_3f11", {18'd0, vaddr}, 32'h3F11);
    check_view("mir10");

    // Non-palette write with +32: nothing stored
    set_addr(16'h2000);
    cpu_wr(1'b1, 8'h11, 1'b1);
    chk("vaddr_2020", {18'd0, vaddr}, 32'h2020);
    check_view("nopal");

    // Top of VRAM, +1 wrap; high address byte bits 7:6 discarded
    set_addr(16'hFFFF);
    chk("vaddr_3fff", {18'd0, vaddr}, 32'h3FFF);
    cpu_wr(1'b1, 8'h2A, 1'b0);
    exp_view[31] = 6'h2A;
    chk("wrap_inc1", {18'd0, vaddr}, 32'h0000);

    // +32 wrap from 3FE0
    set_addr(16'h3FE0);
    cpu_wr(1'b1, 8'h05, 1'b1);
    exp_view[0]  = 6'h05;
    exp_view[16] = 6'h05;
    chk("wrap_inc32", {18'd0, vaddr}, 32'h0000);

    // Data-port access between the two address bytes leaves w alone
    cpu_wr(1'b0, 8'h3F, 1'b0);
    chk("w_hi_only", {18'd0, vaddr}, 32'h3F00);
    cpu_wr(1'b1, 8'h21, 1'b0);
    exp_view[0]  = 6'h21;
    exp_view[16] = 6'h21;
    chk("w_mid_data", {18'd0, vaddr}, 32'h3F01);
    cpu_wr(1'b0, 8'h08, 1'b0);
    chk("w_lo_after_data", {18'd0, vaddr}, 32'h3F08);

    // Other mirror pairs, from both sides
    set_addr(16'h3F1C);
    cpu_wr(1'b1, 8'h3A, 1'b0);
    exp_view[12] = 6'h3A;
    exp_view[28] = 6'h3A;
    set_addr(16'h3F04);
    cpu_wr(1'b1, 8'h07, 1'b0);
    exp_view[4]  = 6'h07;
    exp_view[20] = 6'h07;
    chk("vaddr_3f05", {18'd0, vaddr}, 32'h3F05);
    check_view("wraps");

    // Reset from IDLE, CPU strobes during INIT, then reset again at count 10
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("idle_rst_ready", {31'd0, ready}, 32'd0);
    chk("idle_rst_vaddr", {18'd0, vaddr}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cpu_we = 1'b1; cpu_sel = 1'b0; cpu_din = 8'h3F; inc32 = 1'b0;
    @(negedge clk);
    cpu_sel = 1'b1; cpu_din = 8'h2A;
    @(negedge clk);
    cpu_we = 1'b0;
    chk("init_we_vaddr", {18'd0, vaddr}, 32'h0);
    chk("init_ready_low", {31'd0, ready}, 32'd0);
    repeat (7) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_init_rst_ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    fill_count(n);
    chk("refill_len", n, 32);
    chk("refill_vaddr", {18'd0, vaddr}, 32'h0);
    init_view();
    check_view("refill");
    cpu_wr(1'b0, 8'h3F, 1'b0);
    cpu_wr(1'b0, 8'h02, 1'b0);
    chk("w_clear_after_init", {18'd0, vaddr}, 32'h3F02);

`ifdef PALETTE_READBACK_EN
    // Readback of a stored entry, collision with a write, and mirrored readback
    set_addr(16'h3F01);
    cpu_wr(1'b1, 8'h16, 1'b0);
    cpu_wr(1'b1, 8'h27, 1'b0);
    set_addr(16'h3F01);
    cpu_rd();
    chk("rb_dout", {24'd0, cpu_dout}, 32'h16);
    chk("rb_vaddr", {18'd0, vaddr}, 32'h3F02);
    @(negedge clk);
    cpu_we = 1'b1; cpu_re = 1'b1; cpu_sel = 1'b1; cpu_din = 8'h33; inc32 = 1'b0;
    @(negedge clk);
    cpu_we = 1'b0; cpu_re = 1'b0;
    rd_addr = 5'd2; #1;
    chk("rb_we_wins_data", {26'd0, rd_dout}, 32'h33);
    chk("rb_we_wins_dout", {24'd0, cpu_dout}, 32'h16);
    chk("rb_we_wins_vaddr", {18'd0, vaddr}, 32'h3F03);
    set_addr(16'h3F00);
    cpu_wr(1'b1, 8'h2B, 1'b0);
    set_addr(16'h3F10);
    cpu_rd();
    chk("rb_mirror_dout", {24'd0, cpu_dout}, 32'h2B);
    chk("rb_mirror_vaddr", {18'd0, vaddr}, 32'h3F11);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
